// File: rtl/life_ctrl_pkg.sv
// Shared types and constants for the 16x16 life array sequencing controller.
// Holds the FSM state encoding, array geometry and the row index type.
package life_ctrl_pkg;

  localparam int ROWS  = 16;
  localparam int WIDTH = 16;
  localparam int ROW_W = 4;

  typedef logic [ROW_W-1:0] row_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCAN,
    WAIT,
    STEP
  } state_t;

  function automatic logic is_last_row(input row_idx_t r);
    return r == row_idx_t'(ROWS - 1);
  endfunction

endpackage

// File: rtl/life_step_timer.sv
// Step-period divider: load, decrement to zero and hold, zero flag.
// Latency: zero is a registered flag, valid the cycle after load; no backpressure.
module life_step_timer #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [DIV_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/life_ctrl_16x16.sv
// Load/step/scan sequencer for the 16x16 life array; optional LIFE_CTRL_STABLE_DETECT_EN ends a run on a still frame.
// Latency: one state per cycle, out_row is combinational from the array; out_ready stalls the scan, load_valid gates writes.
module life_ctrl_16x16
  import life_ctrl_pkg::*;
#(
  parameter int ROWS  = 16,
  parameter int WIDTH = 16,
  parameter int GEN_W = 16,
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [GEN_W-1:0] gen_count,
  input  logic [DIV_W-1:0] step_period,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic [WIDTH-1:0] out_row,
  output logic [3:0]       out_row_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [GEN_W-1:0] gen_done,
  output logic             busy,
  output logic             stable,
  output logic [WIDTH-1:0] arr_vali,
  output logic [3:0]       arr_vali_sel,
  output logic             arr_write_enb,
  output logic             arr_step,
  output logic [3:0]       arr_valo_sel,
  input  logic [WIDTH-1:0] arr_valo,
  input  logic [WIDTH-1:0] arr_valo_prev
);

  state_t           state_q, state_d;
  row_idx_t         row_q, row_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             stop_seen_q, stop_seen_d;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [DIV_W-1:0] div_load_val;
  logic             start_acc, last_beat, run_done, stable_hit;

  assign start_acc    = (state_q == IDLE) && start && !stop;
  assign last_beat    = (state_q == SCAN) && out_ready && is_last_row(row_q);
  assign div_load_val = (step_period == '0) ? '0 : step_period - 1'b1;
  assign tmr_dec      = (state_q == WAIT);

  // Any stop seen during the frame, the generation target, or a still frame ends the run.
  assign run_done = stop || stop_seen_q || stable_hit ||
                    ((gen_count != '0) && (gen_q == gen_count));

`ifdef LIFE_CTRL_STABLE_DETECT_EN
  logic diff_q, stepped_q, stable_q, row_diff;

  assign row_diff   = (arr_valo != arr_valo_prev);
  assign stable_hit = stepped_q && !(diff_q || row_diff);

  always_ff @(posedge clk) begin
    if (reset) begin
      diff_q    <= 1'b0;
      stepped_q <= 1'b0;
      stable_q  <= 1'b0;
    end else begin
      if (start_acc) begin
        stepped_q <= 1'b0;
        stable_q  <= 1'b0;
      end else if (state_q == STEP) begin
        stepped_q <= 1'b1;
      end
      // diff covers exactly one frame; cleared everywhere outside SCAN
      if (state_q != SCAN) begin
        diff_q <= 1'b0;
      end else if (out_ready) begin
        diff_q <= diff_q | row_diff;
      end
      if (last_beat && stable_hit) begin
        stable_q <= 1'b1;
      end
    end
  end

  assign stable = stable_q;
`else
  logic unused_prev;
  assign unused_prev = ^arr_valo_prev;
  assign stable_hit  = 1'b0;
  assign stable      = 1'b0;
`endif

  life_step_timer #(.DIV_W(DIV_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (div_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    gen_d       = gen_q;
    stop_seen_d = stop_seen_q;
    tmr_load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          state_d = LOAD;
          row_d   = '0;
          gen_d   = '0;
        end
      end
      LOAD: begin
        if (stop) begin
          state_d = IDLE;
        end else if (load_valid) begin
          row_d = row_q + 1'b1;
          if (is_last_row(row_q)) begin
            state_d     = SCAN;
            row_d       = '0;
            stop_seen_d = 1'b0;
          end
        end
      end
      SCAN: begin
        if (stop) begin
          stop_seen_d = 1'b1;
        end
        if (out_ready) begin
          row_d = row_q + 1'b1;
          if (is_last_row(row_q)) begin
            row_d = '0;
            if (run_done) begin
              state_d = IDLE;
            end else begin
              state_d  = WAIT;
              tmr_load = 1'b1;
            end
          end
        end
      end
      WAIT: begin
        if (stop) begin
          state_d = IDLE;
        end else if (tmr_zero) begin
          state_d = STEP;
        end
      end
      STEP: begin
        state_d     = SCAN;
        row_d       = '0;
        gen_d       = gen_q + 1'b1;
        stop_seen_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      gen_q       <= '0;
      stop_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      gen_q       <= gen_d;
      stop_seen_q <= stop_seen_d;
    end
  end

  assign load_ready    = (state_q == LOAD);
  assign arr_write_enb = (state_q == LOAD) && load_valid;
  assign arr_vali      = load_data;
  assign arr_vali_sel  = row_q;
  assign out_valid     = (state_q == SCAN);
  assign out_row_idx   = row_q;
  assign out_row       = arr_valo;
  assign arr_valo_sel  = row_q;
  assign out_last      = out_valid && is_last_row(row_q);
  assign arr_step      = (state_q == STEP);
  assign busy          = (state_q != IDLE);
  assign gen_done      = gen_q;

endmodule

// File: tb/tb_life_ctrl_16x16.sv
// Bench for life_ctrl_16x16: behavioural life array plus a frame-level reference model.
// Build with +define+LIFE_CTRL_STABLE_DETECT_EN to exercise still-frame termination.
module tb_life_ctrl_16x16;

  typedef logic [255:0] grid_t;
  typedef struct {
    int gc;
    int sp;
    bit bp;
    bit gaps;
    int pat;
    int exp_steps;
  } vec_t;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0;
  logic [15:0] gen_count = '0;
  logic [23:0] step_period = '0;
  logic [15:0] load_data = '0;
  logic        load_valid = 1'b0, out_ready = 1'b0;
  logic        load_ready, out_valid, out_last, busy, stable;
  logic        arr_write_enb, arr_step;
  logic [15:0] out_row, gen_done, arr_vali, arr_valo, arr_valo_prev;
  logic [3:0]  out_row_idx, arr_vali_sel, arr_valo_sel;

  life_ctrl_16x16 dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .gen_count(gen_count), .step_period(step_period),
    .load_data(load_data), .load_valid(load_valid), .load_ready(load_ready),
    .out_row(out_row), .out_row_idx(out_row_idx), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .gen_done(gen_done),
    .busy(busy), .stable(stable), .arr_vali(arr_vali), .arr_vali_sel(arr_vali_sel),
    .arr_write_enb(arr_write_enb), .arr_step(arr_step), .arr_valo_sel(arr_valo_sel),
    .arr_valo(arr_valo), .arr_valo_prev(arr_valo_prev)
  );

  always #5 clk = ~clk;

  // Conway rules, dead cells beyond the 16x16 edge; bit c of row r is g[r*16+c].
  function automatic grid_t life_next(input grid_t g);
    grid_t n = '0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        int cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr = r + dr;
            int cc = c + dc;
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < 16 && cc >= 0 && cc < 16)
              cnt += int'(g[rr*16+cc]);
          end
        end
        n[r*16+c] = (cnt == 3) || (g[r*16+c] && cnt == 2);
      end
    end
    return n;
  endfunction

  grid_t memg = '0;
  grid_t prvg = '0;
  assign arr_valo      = memg[{arr_valo_sel, 4'b0000} +: 16];
  assign arr_valo_prev = prvg[{arr_valo_sel, 4'b0000} +: 16];

  always @(posedge clk) begin
    if (arr_write_enb) memg[{arr_vali_sel, 4'b0000} +: 16] <= arr_vali;
    if (arr_step) begin
      prvg <= memg;
      memg <= life_next(memg);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit mon_en = 1'b0;
  int nsteps = 0, nwr = 0, viol = 0;
  int step_cyc[$];
  logic [3:0] wr_rows[$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (arr_step) begin
        nsteps <= nsteps + 1;
        step_cyc.push_back(cyc);
      end
      if (arr_write_enb) begin
        nwr <= nwr + 1;
        wr_rows.push_back(arr_vali_sel);
      end
      viol <= viol + int'(arr_step && arr_write_enb) + int'(arr_write_enb && !load_ready)
                   + int'(out_last != (out_valid && out_row_idx == 4'd15));
    end
  end

  int checks = 0, errors = 0;
  int s_base = 0;
  logic [15:0] cap[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rst_vec();
    return 256'({load_ready, out_valid, out_last, arr_write_enb, arr_step, busy, stable,
                 arr_vali_sel, arr_valo_sel, out_row_idx, gen_done});
  endfunction

  function automatic grid_t pat_of(input int sel);
    grid_t g = '0;
    case (sel)
      0: g[7*16 +: 16] = 16'h0380;
      1: begin
        g[1*16 +: 16] = 16'h0004;
        g[2*16 +: 16] = 16'h0008;
        g[3*16 +: 16] = 16'h000E;
      end
      2: for (int r = 0; r < 16; r++) g[r*16 +: 16] = 16'($urandom) | 16'($urandom);
      default: begin
        g[4*16 +: 16] = 16'h0030;
        g[5*16 +: 16] = 16'h0030;
      end
    endcase
    return g;
  endfunction

  task automatic do_load(input grid_t p, input bit gaps);
    int r = 0;
    int guard = 0;
    bit acc;
    while (r < 16 && guard < 2000) begin
      load_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      load_data  = p[r*16 +: 16];
      #1;
      acc = load_valid && load_ready;
      tick();
      if (acc) r++;
      guard++;
    end
    load_valid = 1'b0;
    if (r != 16) chk("load_timeout", 256'(r), 256'(16));
  endtask

  task automatic collect(input bit bp, input int stop_after, input int budget);
    int n = 0;
    int exp_idx = 0;
    bit stop_done = 1'b0;
    while (busy && n < budget) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      stop = (stop_after >= 0) && !stop_done && out_valid &&
             ((nsteps - s_base) == stop_after) && (exp_idx == 3);
      if (stop) stop_done = 1'b1;
      #1;
      if (out_valid && out_ready) begin
        chk("row_order", 256'(out_row_idx), 256'(exp_idx));
        cap.push_back(out_row);
        exp_idx = (exp_idx + 1) % 16;
      end
      tick();
      n++;
    end
    stop = 1'b0;
    if (busy) chk("run_timeout", 256'(busy), 256'(0));
  endtask

  task automatic run_cfg(input string tag, input grid_t p, input int gc, input int sp,
                         input bit bp, input bit gaps, input int stop_after, input int exp_steps);
    grid_t cur, nx, got;
    grid_t exq[$];
    int lim, fr, sc0, v0;
    cap.delete();
    s_base = nsteps;
    sc0 = step_cyc.size();
    v0 = viol;
    gen_count = 16'(gc);
    step_period = 24'(sp);
    start = 1'b1;
    tick();
    start = 1'b0;
    do_load(p, gaps);
    collect(bp, stop_after, 20000);
    // expected frames straight from the life rules
    lim = (stop_after >= 0) ? stop_after : ((gc == 0) ? 64 : gc);
    cur = p;
    exq.push_back(p);
    for (int k = 1; k <= lim; k++) begin
      nx = life_next(cur);
      exq.push_back(nx);
`ifdef LIFE_CTRL_STABLE_DETECT_EN
      if (nx == cur) break;
`endif
      cur = nx;
    end
    fr = exq.size();
    chk($sformatf("%s_beats", tag), 256'(cap.size()), 256'(16 * fr));
    for (int f = 0; f < fr; f++) begin
      for (int r = 0; r < 16; r++) got[r*16 +: 16] = cap[f*16 + r];
      chk($sformatf("%s_frame%0d", tag, f), got, exq[f]);
    end
    chk($sformatf("%s_steps", tag), 256'(nsteps - s_base), 256'(fr - 1));
    if (exp_steps >= 0) chk($sformatf("%s_tbl_steps", tag), 256'(nsteps - s_base), 256'(exp_steps));
    chk($sformatf("%s_gen_done", tag), 256'(gen_done), 256'(fr - 1));
    chk($sformatf("%s_idle", tag), 256'(busy), 256'(0));
    chk($sformatf("%s_protocol", tag), 256'(viol - v0), 256'(0));
    if (!bp && stop_after < 0) begin
      for (int i = sc0 + 1; i < step_cyc.size(); i++)
        chk($sformatf("%s_spacing", tag), 256'(step_cyc[i] - step_cyc[i-1]),
            256'(17 + ((sp == 0) ? 1 : sp)));
    end
  endtask

  vec_t vt[5];

  initial begin
    int w0, n0;
    logic [19:0] rows;

    vt[0] = '{gc: 1, sp: 0, bp: 1'b0, gaps: 1'b0, pat: 1, exp_steps: 1};
    vt[1] = '{gc: 3, sp: 5, bp: 1'b1, gaps: 1'b1, pat: 1, exp_steps: 3};
    vt[2] = '{gc: 2, sp: 3, bp: 1'b0, gaps: 1'b1, pat: 2, exp_steps: -1};
    vt[3] = '{gc: 4, sp: 1, bp: 1'b1, gaps: 1'b0, pat: 2, exp_steps: -1};
    vt[4] = '{gc: 1, sp: 6, bp: 1'b1, gaps: 1'b1, pat: 0, exp_steps: 1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", rst_vec(), '0);
    reset = 1'b0;
    mon_en = 1'b1;
    tick();

    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("start_with_stop_idle", 256'(busy), 256'(0));

    run_cfg("blinker", pat_of(0), 2, 4, 1'b0, 1'b0, -1, 2);
    chk("blink_f0_r7", 256'(cap[7]), 256'(16'h0380));
    chk("blink_f1_r678", 256'({cap[16+6], cap[16+7], cap[16+8]}), 256'(48'h0100_0100_0100));
    chk("blink_f2_r7", 256'(cap[32+7]), 256'(16'h0380));

    for (int i = 0; i < 5; i++)
      run_cfg($sformatf("vec%0d", i), pat_of(vt[i].pat), vt[i].gc, vt[i].sp,
              vt[i].bp, vt[i].gaps, -1, vt[i].exp_steps);

    run_cfg("freerun_stop", pat_of(0), 0, 3, 1'b1, 1'b0, 2, 2);

    // stop in the middle of a long WAIT
    s_base = nsteps;
    gen_count = 16'd3;
    step_period = 24'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    do_load(pat_of(0), 1'b0);
    out_ready = 1'b1;
    repeat (16) tick();
    repeat (30) tick();
    chk("wait_state", 256'({busy, out_valid}), 256'(2'b10));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("wait_stop_idle", 256'(busy), 256'(0));
    chk("wait_stop_no_step", 256'(nsteps - s_base), 256'(0));
    chk("wait_stop_gen_done", 256'(gen_done), 256'(0));

    // reset in the middle of a frame, then a normal run
    gen_count = 16'd2;
    step_period = 24'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    do_load(pat_of(0), 1'b0);
    out_ready = 1'b1;
    repeat (5) tick();
    chk("scan_before_reset", 256'(out_valid), 256'(1));
    reset = 1'b1;
    tick();
    chk("reset_mid_scan", rst_vec(), '0);
    reset = 1'b0;
    tick();
    run_cfg("after_reset", pat_of(1), 1, 2, 1'b0, 1'b1, -1, 1);

`ifdef LIFE_CTRL_STABLE_DETECT_EN
    run_cfg("block", pat_of(3), 0, 2, 1'b0, 1'b0, -1, 1);
    chk("block_stable", 256'(stable), 256'(1));
`else
    run_cfg("block", pat_of(3), 1, 2, 1'b0, 1'b0, -1, 1);
    chk("block_stable_off", 256'(stable), 256'(0));
`endif

    // stop after five load beats
    w0 = wr_rows.size();
    n0 = nwr;
    gen_count = 16'd2;
    step_period = 24'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_clears_stable", 256'(stable), 256'(0));
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_data = 16'(16'hA500 + i);
      tick();
    end
    load_valid = 1'b0;
    stop = 1'b1;
    #1;
    chk("load_ready_before_stop", 256'(load_ready), 256'(1));
    tick();
    stop = 1'b0;
    chk("load_stop_ready_low", 256'({load_ready, busy}), 256'(0));
    chk("load_stop_writes", 256'(nwr - n0), 256'(5));
    rows = '0;
    for (int i = 0; i < 5 && (w0 + i) < wr_rows.size(); i++) rows[i*4 +: 4] = wr_rows[w0 + i];
    chk("load_stop_rows", 256'(rows), 256'(20'h43210));
    chk("load_stop_array_r4", 256'(memg[4*16 +: 16]), 256'(16'hA504));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/life_ctrl_16x16.md
Name: life_ctrl_16x16

Overview:
- Sequencing controller for the 16x16 life array.
- Loads an initial pattern row by row from a valid/ready stream.
- Issues single-cycle step pulses at a programmable period for a programmable number of generations.
- Scans every generation out row by row on a valid/ready stream to the display/frame-buffer side.
- Sits between the system interface and the 16x16 array; it is the only driver of the array's write, select and step inputs.

Parameters:
ROWS, 16, number of array rows; row index width is 4.
WIDTH, 16, row width in cells.
GEN_W, 16, width of the generation target and generation counter.
DIV_W, 24, width of the step-period divider.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high; returns the FSM to IDLE.
start  in  1  pulse; begins a load/run sequence; honoured only in IDLE.
stop  in  1  level or pulse; requests early termination.
gen_count  in  GEN_W  generations to run; 0 = free-run until stop.
step_period  in  DIV_W  cycles between the end of a scan and the next step; 0 treated as 1.
load_data  in  WIDTH  initial row data.
load_valid  in  1  load_data valid.
load_ready  out  1  high in LOAD.
out_row  out  WIDTH  scanned row (arr_valo pass-through).
out_row_idx  out  4  index of out_row.
out_valid  out  1  high in SCAN.
out_ready  in  1  sink accepts out_row.
out_last  out  1  out_valid && out_row_idx==15.
gen_done  out  GEN_W  steps issued since start.
busy  out  1  state != IDLE.
stable  out  1  see Optional Feature.
arr_vali  out  WIDTH  to array vali.
arr_vali_sel  out  4  to array vali_selector.
arr_write_enb  out  1  to array write_enb.
arr_step  out  1  to array step.
arr_valo_sel  out  4  to array valo_selector.
arr_valo  in  WIDTH  from array valo (combinational on the selector).
arr_valo_prev  in  WIDTH  from array valo_prev.

Behaviour:
- Reset values: state=IDLE, row counter=0, gen_done=0, divider=0, stable=0.
- Resulting outputs at reset: load_ready, out_valid, out_last, arr_write_enb, arr_step and busy all 0; arr_*_sel=0.
- Reset mid-operation aborts immediately. Array contents are not cleared by this block.

States and transitions:
- IDLE: on start && !stop, clear gen_done and row counter, go to LOAD. start && stop in the same cycle: stay in IDLE.
- LOAD:
  - load_ready=1; arr_write_enb = load_valid; arr_vali = load_data; arr_vali_sel = row counter.
  - Each accepted beat increments the row counter.
  - The beat at row 15 goes to SCAN with row counter=0.
  - stop goes to IDLE; partially loaded rows remain in the array.
- SCAN:
  - out_valid=1; arr_valo_sel = out_row_idx = row counter; out_row = arr_valo combinationally.
  - The row counter advances on out_valid && out_ready.
  - On the beat where out_last && out_ready:
    - If stop is seen during the scan, or gen_count!=0 && gen_done==gen_count, go to IDLE.
    - Otherwise go to WAIT with the divider loaded to max(step_period,1)-1.
  - stop is latched into a sticky flag during SCAN; the frame always completes.
- WAIT:
  - The divider decrements each cycle; at 0, go to STEP.
  - stop goes to IDLE with no step issued.
- STEP:
  - arr_step=1 for exactly one cycle; gen_done increments (wraps in free-run); go to SCAN with row counter=0.
  - The array updates at this edge, so the first SCAN row reflects the new generation.

Timing and ordering:
- A gen_count=N run produces N+1 frames: the initial frame plus N stepped frames.
- Step-to-step spacing is 16 (scan, zero backpressure) + step_period + 1 cycles.
- arr_write_enb and arr_step are never high in the same cycle.
- arr_write_enb is never high outside LOAD.

Optional Feature:
- Macro: LIFE_CTRL_STABLE_DETECT_EN.
- Enabled:
  - During a SCAN following at least one step, a sticky "diff" flag ORs in (arr_valo != arr_valo_prev) on each accepted row.
  - At the last beat, if diff=0, set stable=1 and go to IDLE regardless of gen_count.
  - stable clears on the next accepted start.
- Disabled: stable is tied 0 and there is no compare logic.

Decomposition:
- Package life_ctrl_pkg: state enum (IDLE, LOAD, SCAN, WAIT, STEP), ROWS/WIDTH constants, row index typedef.
- One sub-module: life_step_timer (load/decrement/zero-flag divider, DIV_W wide).

Test Plan:
- Blinker run: load row7=16'h0380, all other rows 0, gen_count=2, step_period=4. Required response:
  - frame 0 shows row7=16'h0380;
  - frame 1 shows rows 6-8=16'h0100;
  - frame 2 shows row7=16'h0380 again;
  - exactly 2 arr_step pulses, gen_done=2, then IDLE.
- Backpressure: toggle out_ready randomly during SCAN. Required: each row index 0..15 is emitted once, in order; out_last appears only at idx 15; no step is issued until the frame completes.
- Stop in WAIT: stop with step_period=100, mid-WAIT. Required: IDLE the next cycle, no arr_step, gen_done unchanged.
- Stop during LOAD after 5 beats: required IDLE; load_ready drops the following cycle; exactly 5 write pulses on rows 0..4.
- Reset asserted mid-SCAN: required all outputs at reset values the next cycle; a subsequent start runs a full load normally.
- With LIFE_CTRL_STABLE_DETECT_EN: load a 2x2 block, gen_count=0. Required: after step 1, stable=1, IDLE, gen_done=1.
